samsun_core: RTL and testbench
==============================

SAMSUN_CORE -- requirements
Module: samsun_core

Interface
REQ-001 SHALL: clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL: rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: imem_request_pc_o  out  32  fetch address, equal to the PC register.
REQ-004 SHALL: imem_response_pc_i  in  32  address of the returned word; instruction memory reads combinationally, same cycle.
REQ-005 SHALL: imem_response_instr_i  in  32  instruction word.
REQ-006 SHALL: br_taken_i  in  1  redirect request; br_tgt_addr_i  in  32  redirect target.
REQ-007 SHALL: exec_ctrl_signal_o  out  13  control bundle: [3:0] alu_op, [4] rd_we, [5] mem_rd, [6] mem_wr, [9:7] funct3, [10] branch, [11] jump, [12] valid.
REQ-008 SHALL: exec_operand1_o / exec_operand2_o / exec_rs2_o  out  32  ALU operands and rs2 value.
REQ-009 SHALL: exec_rd_addr_o  out  5; exec_pc_o  out  32  PC of the issued instruction.
REQ-010 SHALL: exec_flush_i  in  1  kill in-flight instructions; exec_ready_i  in  1  execute accepts the issued slot.
REQ-011 SHALL: wb_rd_addr_i  in  5, wb_rd_i  in  32, wb_rd_en_i  in  1  register-file write port.

Function
REQ-012 SHALL: three registered stages: PC -> IF/ID (instr, pc, valid) -> ID/EX (drives all exec_* outputs).
REQ-013 SHALL: PC advance by 4 each cycle while exec_ready_i=1 and br_taken_i=0.
REQ-014 SHALL: IF/ID capture imem_response_instr_i and imem_response_pc_i with valid=1 each advancing cycle.
REQ-015 SHALL: alu_op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
REQ-016 SHALL: decode OP/OP-IMM: op1=rs1, op2=rs2 or sign-extended I-imm (shamt for shifts), rd_we=1.
REQ-017 SHALL: decode LUI: op1=0, op2=U-imm, ADD; AUIPC: op1=pc, op2=U-imm, ADD; both rd_we=1.
REQ-018 SHALL: decode LOAD: op1=rs1, op2=I-imm, ADD, mem_rd=1, rd_we=1; STORE: op1=rs1, op2=S-imm, ADD, mem_wr=1, exec_rs2_o=rs2.
REQ-019 SHALL: decode BRANCH: op1=rs1, exec_rs2_o=rs2, op2=pc+B-imm (precomputed target), branch=1.
REQ-020 SHALL: decode JAL: op1=pc, op2=J-imm; JALR: op1=rs1, op2=I-imm; both ADD, jump=1, rd_we=1.
REQ-021 SHALL: funct3 field carry instr[14:12] for every instruction; unused fields zero.
REQ-022 SHALL: unrecognised opcode or invalid IF/ID slot issue a bubble (exec_ctrl_signal_o=0).
REQ-023 SHALL: register file 32x32, x0 reads 0, writes to x0 ignored, write on rising edge when wb_rd_en_i=1.
REQ-024 SHALL: exec_ready_i=0 hold PC, IF/ID and ID/EX unchanged.
REQ-025 SHALL: br_taken_i=1 load PC with br_tgt_addr_i and clear IF/ID and ID/EX valid, regardless of exec_ready_i.
REQ-026 SHALL: exec_flush_i=1 clear IF/ID and ID/EX valid; PC behaves per REQ-013/REQ-025.
REQ-027 SHALL: first instruction after reset release appear on exec_* outputs after two rising edges.

Reset
REQ-028 SHALL: rst_ni=0 asynchronously set PC=0x0000_0000, all stage valids 0, all exec_* outputs 0.
REQ-029 SHALL: register file not reset; reads of unwritten registers are X.
REQ-030 SHALL: reset asserted mid-operation discard all in-flight instructions.

Configuration
REQ-031 SHALL: macro SAMSUN_CORE_WB_BYPASS_EN defined: decode read of a register being written the same cycle returns wb_rd_i.
REQ-032 SHALL: macro undefined: decode returns the pre-write register value in that case.

Verification
REQ-033 SHALL: reset low then released -> outputs 0; imem_request_pc_o 0,4,8,12 on successive edges.
REQ-034 SHALL: 0x00500093 (ADDI x1,x0,5) at 0 -> 2 edges later ctrl=0x1010, op1=0, op2=5, rd=1, pc=0.
REQ-035 SHALL: write x2=0x1234 then ADD x3,x2,x2 -> op1=op2=0x1234; write x0=0xFFFF -> x0 reads 0.
REQ-036 SHALL: 0x123452B7 (LUI x5) -> op1=0, op2=0x12345000, rd=5, rd_we=1.
REQ-037 SHALL: br_taken_i=1, target 0x40 -> next PC 0x40, valid=0 two cycles, then pc 0x40 issues.
REQ-038 SHALL: exec_ready_i=0 for 3 cycles -> PC and all exec_* outputs constant; resume advances normally.

Source files
------------

// File: rtl/samsun_core.sv
// samsun_core: three-stage PC -> IF/ID -> ID/EX fetch/decode front end with a 32x32 register file.
// Optional macro SAMSUN_CORE_WB_BYPASS_EN forwards same-cycle writeback data into decode reads.
module samsun_core (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [31:0] imem_request_pc_o,
   input  logic [31:0] imem_response_pc_i,
   input  logic [31:0] imem_response_instr_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_tgt_addr_i,
   output logic [12:0] exec_ctrl_signal_o,
   output logic [31:0] exec_operand1_o,
   output logic [31:0] exec_operand2_o,
   output logic [31:0] exec_rs2_o,
   output logic [4:0]  exec_rd_addr_o,
   output logic [31:0] exec_pc_o,
   input  logic        exec_flush_i,
   input  logic        exec_ready_i,
   input  logic [4:0]  wb_rd_addr_i,
   input  logic [31:0] wb_rd_i,
   input  logic        wb_rd_en_i
);

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;

   logic [31:0] pc_q;
   logic [31:0] ifid_instr_q, ifid_pc_q;
   logic        ifid_valid_q;
   logic [31:0] rf_q [32];
   logic        kill;

   assign imem_request_pc_o = pc_q;
   assign kill              = br_taken_i | exec_flush_i;

   // Fetch: the redirect wins over a stall so a taken branch is never lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q         <= 32'h0;
         ifid_instr_q <= 32'h0;
         ifid_pc_q    <= 32'h0;
         ifid_valid_q <= 1'b0;
      end else begin
         if (br_taken_i) pc_q <= br_tgt_addr_i;
         else if (exec_ready_i) pc_q <= pc_q + 32'd4;
         if (kill) begin
            ifid_valid_q <= 1'b0;
         end else if (exec_ready_i) begin
            ifid_instr_q <= imem_response_instr_i;
            ifid_pc_q    <= imem_response_pc_i;
            ifid_valid_q <= 1'b1;
         end
      end
   end

   // Register file holds no reset; x0 is never written.
   always_ff @(posedge clk_i) begin
      if (wb_rd_en_i && (wb_rd_addr_i != 5'd0)) rf_q[wb_rd_addr_i] <= wb_rd_i;
   end

   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rs1_val, rs2_val;
   assign rs1 = ifid_instr_q[19:15];
   assign rs2 = ifid_instr_q[24:20];
   assign rd  = ifid_instr_q[11:7];

   always_comb begin
      rs1_val = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
      rs2_val = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];
`ifdef SAMSUN_CORE_WB_BYPASS_EN
      if (wb_rd_en_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs1)) rs1_val = wb_rd_i;
      if (wb_rd_en_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs2)) rs2_val = wb_rd_i;
`endif
   end

   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   assign i_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
   assign s_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
   assign b_imm = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                   ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
   assign u_imm = {ifid_instr_q[31:12], 12'h0};
   assign j_imm = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                   ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

   logic [2:0]  funct3;
   logic [3:0]  alu_op, arith_op;
   logic        rd_we, mem_rd, mem_wr, branch, jump, dec_valid;
   logic [31:0] op1, op2, rs2_out;
   logic [4:0]  rd_out;
   logic [12:0] ctrl;
   assign funct3 = ifid_instr_q[14:12];

   // SUB/SRA selection by funct7[5]; OP-IMM only honours it for shifts.
   always_comb begin
      unique case (funct3)
         3'd0:    arith_op = (ifid_instr_q[6:0] == OpcOp && ifid_instr_q[30]) ? 4'd1 : 4'd0;
         3'd1:    arith_op = 4'd2;
         3'd2:    arith_op = 4'd3;
         3'd3:    arith_op = 4'd4;
         3'd4:    arith_op = 4'd5;
         3'd5:    arith_op = ifid_instr_q[30] ? 4'd7 : 4'd6;
         3'd6:    arith_op = 4'd8;
         default: arith_op = 4'd9;
      endcase
   end

   always_comb begin
      alu_op = 4'd0; rd_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      branch = 1'b0; jump = 1'b0; dec_valid = 1'b1;
      op1 = 32'h0; op2 = 32'h0; rs2_out = 32'h0;
      case (ifid_instr_q[6:0])
         OpcOp:     begin op1 = rs1_val; op2 = rs2_val; alu_op = arith_op; rd_we = 1'b1; end
         OpcOpImm:  begin
            op1 = rs1_val; alu_op = arith_op; rd_we = 1'b1;
            op2 = (funct3 == 3'd1 || funct3 == 3'd5) ? {27'h0, ifid_instr_q[24:20]} : i_imm;
         end
         OpcLui:    begin op2 = u_imm; rd_we = 1'b1; end
         OpcAuipc:  begin op1 = ifid_pc_q; op2 = u_imm; rd_we = 1'b1; end
         OpcLoad:   begin op1 = rs1_val; op2 = i_imm; mem_rd = 1'b1; rd_we = 1'b1; end
         OpcStore:  begin op1 = rs1_val; op2 = s_imm; mem_wr = 1'b1; rs2_out = rs2_val; end
         OpcBranch: begin
            op1 = rs1_val; op2 = ifid_pc_q + b_imm; rs2_out = rs2_val; branch = 1'b1;
         end
         OpcJal:    begin op1 = ifid_pc_q; op2 = j_imm; jump = 1'b1; rd_we = 1'b1; end
         OpcJalr:   begin op1 = rs1_val; op2 = i_imm; jump = 1'b1; rd_we = 1'b1; end
         default:   dec_valid = 1'b0;
      endcase
      rd_out = rd_we ? rd : 5'd0;
      ctrl   = {1'b1, jump, branch, funct3, mem_wr, mem_rd, rd_we, alu_op};
   end

   // Bubbles present an all-zero slot on every exec_* output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exec_ctrl_signal_o <= 13'h0;
         exec_operand1_o    <= 32'h0;
         exec_operand2_o    <= 32'h0;
         exec_rs2_o         <= 32'h0;
         exec_rd_addr_o     <= 5'h0;
         exec_pc_o          <= 32'h0;
      end else if (kill || (exec_ready_i && !(ifid_valid_q && dec_valid))) begin
         exec_ctrl_signal_o <= 13'h0;
         exec_operand1_o    <= 32'h0;
         exec_operand2_o    <= 32'h0;
         exec_rs2_o         <= 32'h0;
         exec_rd_addr_o     <= 5'h0;
         exec_pc_o          <= 32'h0;
      end else if (exec_ready_i) begin
         exec_ctrl_signal_o <= ctrl;
         exec_operand1_o    <= op1;
         exec_operand2_o    <= op2;
         exec_rs2_o         <= rs2_out;
         exec_rd_addr_o     <= rd_out;
         exec_pc_o          <= ifid_pc_q;
      end
   end

endmodule

// File: tb/tb_samsun_core.sv
// Directed bench for samsun_core: reset, decode of several formats, stall, redirect, flush.
module tb_samsun_core;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] imem_request_pc_o, imem_response_pc_i, imem_response_instr_i;
   logic        br_taken_i;
   logic [31:0] br_tgt_addr_i;
   logic [12:0] exec_ctrl_signal_o;
   logic [31:0] exec_operand1_o, exec_operand2_o, exec_rs2_o, exec_pc_o;
   logic [4:0]  exec_rd_addr_o;
   logic        exec_flush_i, exec_ready_i;
   logic [4:0]  wb_rd_addr_i;
   logic [31:0] wb_rd_i;
   logic        wb_rd_en_i;

   logic [31:0] imem [64];
   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   assign imem_response_pc_i    = imem_request_pc_o;
   assign imem_response_instr_i = imem[imem_request_pc_o[7:2]];

   samsun_core dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .imem_request_pc_o(imem_request_pc_o), .imem_response_pc_i(imem_response_pc_i),
      .imem_response_instr_i(imem_response_instr_i),
      .br_taken_i(br_taken_i), .br_tgt_addr_i(br_tgt_addr_i),
      .exec_ctrl_signal_o(exec_ctrl_signal_o), .exec_operand1_o(exec_operand1_o),
      .exec_operand2_o(exec_operand2_o), .exec_rs2_o(exec_rs2_o),
      .exec_rd_addr_o(exec_rd_addr_o), .exec_pc_o(exec_pc_o),
      .exec_flush_i(exec_flush_i), .exec_ready_i(exec_ready_i),
      .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_i(wb_rd_i), .wb_rd_en_i(wb_rd_en_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic slot(input string tag, input logic [31:0] ctrl, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [31:0] rs2, input logic [31:0] rd,
                       input logic [31:0] pc);
      check({tag, ".ctrl"}, {19'h0, exec_ctrl_signal_o}, ctrl);
      check({tag, ".op1"}, exec_operand1_o, op1);
      check({tag, ".op2"}, exec_operand2_o, op2);
      check({tag, ".rs2"}, exec_rs2_o, rs2);
      check({tag, ".rd"}, {27'h0, exec_rd_addr_o}, rd);
      check({tag, ".pc"}, exec_pc_o, pc);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
      imem[0]  = 32'h00500093;  // ADDI x1,x0,5
      imem[1]  = 32'h123452B7;  // LUI x5,0x12345
      imem[2]  = 32'h002101B3;  // ADD x3,x2,x2
      imem[3]  = 32'h00200233;  // ADD x4,x0,x2
      imem[4]  = 32'h00212423;  // SW x2,8(x2)
      imem[5]  = 32'h40210333;  // SUB x6,x2,x2
      imem[16] = 32'h010000EF;  // JAL x1,16
      imem[17] = 32'h00500093;
      imem[18] = 32'h00500093;
      imem[19] = 32'h00210463;  // BEQ x2,x2,+8

      rst_ni = 1'b0; br_taken_i = 1'b0; br_tgt_addr_i = 32'h0;
      exec_flush_i = 1'b0; exec_ready_i = 1'b1;
      wb_rd_en_i = 1'b0; wb_rd_addr_i = 5'd0; wb_rd_i = 32'h0;
      #2;
      // Preload the register file while reset holds the pipeline.
      wb_rd_en_i = 1'b1; wb_rd_addr_i = 5'd2; wb_rd_i = 32'h1234;
      step();
      wb_rd_addr_i = 5'd0; wb_rd_i = 32'hFFFF;
      step();
      wb_rd_en_i = 1'b0;
      check("rst.pc", imem_request_pc_o, 32'h0);
      slot("rst", 0, 0, 0, 0, 0, 0);
      rst_ni = 1'b1;

      step(); check("pc.e1", imem_request_pc_o, 32'd4);
      check("e1.bubble", {19'h0, exec_ctrl_signal_o}, 32'h0);
      step(); check("pc.e2", imem_request_pc_o, 32'd8);
      slot("addi", 32'h1010, 0, 5, 0, 1, 0);
      step(); check("pc.e3", imem_request_pc_o, 32'd12);
      slot("lui", 32'h1290, 0, 32'h12345000, 0, 5, 4);
      step(); slot("add", 32'h1010, 32'h1234, 32'h1234, 0, 3, 8);
      step(); slot("add_x0", 32'h1010, 0, 32'h1234, 0, 4, 12);
      step(); slot("sw", 32'h1140, 32'h1234, 8, 32'h1234, 0, 16);
      check("pc.e6", imem_request_pc_o, 32'd24);

      exec_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall.pc", imem_request_pc_o, 32'd24);
         slot("stall", 32'h1140, 32'h1234, 8, 32'h1234, 0, 16);
      end
      exec_ready_i = 1'b1;
      step(); slot("sub", 32'h1011, 32'h1234, 32'h1234, 0, 6, 20);
      check("resume.pc", imem_request_pc_o, 32'd28);

      br_taken_i = 1'b1; br_tgt_addr_i = 32'h40;
      step(); br_taken_i = 1'b0;
      check("br.pc", imem_request_pc_o, 32'h40);
      check("br.bubble1", {19'h0, exec_ctrl_signal_o}, 32'h0);
      step(); check("br.bubble2", {19'h0, exec_ctrl_signal_o}, 32'h0);
      step(); slot("jal", 32'h1810, 32'h40, 16, 0, 1, 32'h40);

      exec_flush_i = 1'b1;
      step(); exec_flush_i = 1'b0;
      check("flush.pc", imem_request_pc_o, 32'h4C);
      check("flush.bubble1", {19'h0, exec_ctrl_signal_o}, 32'h0);
      step(); check("flush.bubble2", {19'h0, exec_ctrl_signal_o}, 32'h0);
      step(); slot("beq", 32'h1400, 32'h1234, 32'h54, 32'h1234, 0, 32'h4C);

      #3 rst_ni = 1'b0;
      #1;
      check("arst.pc", imem_request_pc_o, 32'h0);
      slot("arst", 0, 0, 0, 0, 0, 0);
      step();
      check("arst.hold", {19'h0, exec_ctrl_signal_o}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
